// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared constants, helpers and stage-record types for the
//                pipelined multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Number of register stages between operand acceptance and product
    localparam int LATENCY = 3;

    // Full-width product size for a given operand width
    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    // Control part of every stage record; tag and data widths depend on the
    // instantiating module and are added there.
    typedef struct packed {
        logic valid;
        logic is_signed;
    } stage_flags_t;

endpackage
`default_nettype wire

// File: rtl/prefix_adder.sv
`default_nettype none
// ============================================================================
//  Module      : prefix_adder
//  Description : N-bit two-operand Kogge-Stone parallel-prefix adder.
//                Sum only, no carry-in, carry-out discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module prefix_adder
    import mult_pkg::*;
#(
    parameter int N = 16
)
(
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum
);

    localparam int c_levels = (N > 1) ? $clog2(N) : 0;

    logic [N-1:0] w_g0;
    logic [N-1:0] w_p0;
    logic [N-1:0] w_g_final;

    // Bit-level generate / propagate
    assign w_g0 = i_a & i_b;
    assign w_p0 = i_a ^ i_b;

    // Prefix tree: each level doubles the span of every group signal.
    // Bits below the span pass through, bits whose lower neighbour group is
    // already complete use a grey cell (G only), the rest use black cells.
    for (genvar l = 0; l < c_levels; l++) begin : g_level
        localparam int c_dist = 1 << l;
        logic [N-1:0] w_g_in;
        logic [N-1:0] w_p_in;
        logic [N-1:0] w_g;
        logic [N-1:0] w_p;

        if (l == 0) begin : g_from_bits
            assign w_g_in = w_g0;
            assign w_p_in = w_p0;
        end else begin : g_from_prev
            assign w_g_in = g_level[l-1].w_g;
            assign w_p_in = g_level[l-1].w_p;
        end

        for (genvar i = 0; i < N; i++) begin : g_cell
            if (i < c_dist) begin : g_pass
                assign w_g[i] = w_g_in[i];
                assign w_p[i] = w_p_in[i];
            end else if (i < 2 * c_dist) begin : g_grey
                assign w_g[i] = w_g_in[i] | (w_p_in[i] & w_g_in[i-c_dist]);
                assign w_p[i] = w_p_in[i];
            end else begin : g_black
                assign w_g[i] = w_g_in[i] | (w_p_in[i] & w_g_in[i-c_dist]);
                assign w_p[i] = w_p_in[i] & w_p_in[i-c_dist];
            end
        end
    end

    if (c_levels == 0) begin : g_no_levels
        assign w_g_final = w_g0;
    end else begin : g_levels_done
        // Group propagate of the last level is not needed for the sum
        logic w_unused_p;
        assign w_g_final  = g_level[c_levels-1].w_g;
        assign w_unused_p = ^g_level[c_levels-1].w_p;
    end

    // Carry into bit i is the group generate of bits [i-1:0]
    if (N == 1) begin : g_single_bit
        logic w_unused_carry;
        assign o_sum          = w_p0;
        assign w_unused_carry = w_g_final[0];
    end else begin : g_multi_bit
        logic w_unused_carry;
        assign o_sum          = w_p0 ^ {w_g_final[N-2:0], 1'b0};
        assign w_unused_carry = w_g_final[N-1];
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_multiplier
//  Description : Three-stage signed/unsigned array multiplier with
//                valid/ready handshakes. S1 partial products (Baugh-Wooley
//                in signed mode), S2 carry-save reduction, S3 prefix add.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_signed,
    input  logic [WIDTH-1:0]        in_x,
    input  logic [WIDTH-1:0]        in_y,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*WIDTH-1:0]      out_p,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int c_pw         = prod_width(WIDTH);
    localparam int c_rows       = WIDTH + 1;
    localparam int c_num_stages = 3;

    // Baugh-Wooley correction constants at columns WIDTH and 2*WIDTH-1
    localparam logic [c_pw-1:0] c_bw_const =
        (c_pw'(1) << WIDTH) | (c_pw'(1) << (c_pw - 1));

    // The stage registers below are the whole pipeline depth
    if (c_num_stages != LATENCY) begin : g_latency_mismatch
    end

    typedef struct packed {
        stage_flags_t           flags;
        logic [TAG_W-1:0]       tag;
        logic [c_rows*c_pw-1:0] data;
    } s1_t;

    typedef struct packed {
        stage_flags_t           flags;
        logic [TAG_W-1:0]       tag;
        logic [2*c_pw-1:0]      data;
    } s2_t;

    typedef struct packed {
        stage_flags_t           flags;
        logic [TAG_W-1:0]       tag;
        logic [c_pw-1:0]        data;
    } s3_t;

    s1_t r_s1, w_s1_next;
    s2_t r_s2, w_s2_next;
    s3_t r_s3, w_s3_next;

    logic                               w_stall;
    logic [c_rows-1:0][c_pw-1:0]        w_rows;
    logic [c_pw-1:0]                    w_csa_sum;
    logic [c_pw-1:0]                    w_csa_carry;
    logic [c_pw-1:0]                    w_final_sum;
    logic                               w_unused_flags;

    // ------------------------------------------------------------------
    // Flow control: the whole pipe freezes only when the product is held
    // ------------------------------------------------------------------
    assign w_stall   = r_s3.flags.valid & ~out_ready;
    assign in_ready  = ~w_stall;

    // ------------------------------------------------------------------
    // Partial products. In signed mode the terms pairing exactly one sign
    // bit are inverted; the sign*sign term keeps its polarity.
    // ------------------------------------------------------------------
    for (genvar j = 0; j < WIDTH; j++) begin : g_pp_row
        logic [WIDTH-1:0] w_bits;
        for (genvar i = 0; i < WIDTH; i++) begin : g_pp_col
            if ((i == WIDTH - 1) != (j == WIDTH - 1)) begin : g_sign_term
                assign w_bits[i] = (in_x[i] & in_y[j]) ^ in_signed;
            end else begin : g_plain_term
                assign w_bits[i] = in_x[i] & in_y[j];
            end
        end
        assign w_rows[j] = {{WIDTH{1'b0}}, w_bits} << j;
    end

    assign w_rows[WIDTH] = in_signed ? c_bw_const : '0;

    // ------------------------------------------------------------------
    // Carry-save reduction: a chain of 3:2 compressors folds the WIDTH+1
    // registered rows into one sum row and one carry row.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < WIDTH - 1; k++) begin : g_csa
        logic [c_pw-1:0] w_a;
        logic [c_pw-1:0] w_b;
        logic [c_pw-1:0] w_c;
        logic [c_pw-1:0] w_s;
        logic [c_pw-1:0] w_cy;

        if (k == 0) begin : g_first
            assign w_a = r_s1.data[0    +: c_pw];
            assign w_b = r_s1.data[c_pw +: c_pw];
        end else begin : g_next
            assign w_a = g_csa[k-1].w_s;
            assign w_b = g_csa[k-1].w_cy;
        end

        assign w_c  = r_s1.data[(k+2)*c_pw +: c_pw];
        assign w_s  = w_a ^ w_b ^ w_c;
        // Carries out of the top column fall off the 2*WIDTH result
        assign w_cy = {(w_a[c_pw-2:0] & w_b[c_pw-2:0]) |
                       (w_a[c_pw-2:0] & w_c[c_pw-2:0]) |
                       (w_b[c_pw-2:0] & w_c[c_pw-2:0]), 1'b0};
    end

    assign w_csa_sum   = g_csa[WIDTH-2].w_s;
    assign w_csa_carry = g_csa[WIDTH-2].w_cy;

    // ------------------------------------------------------------------
    // Final carry-propagate add of the registered sum/carry rows
    // ------------------------------------------------------------------
    prefix_adder #(
        .N      (c_pw)
    ) u_final_add (
        .i_a    (r_s2.data[2*c_pw-1 -: c_pw]),
        .i_b    (r_s2.data[c_pw-1:0]),
        .o_sum  (w_final_sum)
    );

    // Next contents of every stage when the pipe advances
    always_comb begin
        w_s1_next                 = '0;
        w_s1_next.flags.valid     = in_valid & in_ready;
        w_s1_next.flags.is_signed = in_signed;
        w_s1_next.tag             = in_tag;
        w_s1_next.data            = w_rows;

        w_s2_next                 = '0;
        w_s2_next.flags           = r_s1.flags;
        w_s2_next.tag             = r_s1.tag;
        w_s2_next.data            = {w_csa_sum, w_csa_carry};

        w_s3_next                 = '0;
        w_s3_next.flags           = r_s2.flags;
        w_s3_next.tag             = r_s2.tag;
        w_s3_next.data            = w_final_sum;
    end

    // Stage registers: cleared by reset, frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else if (!w_stall) begin
            r_s1 <= w_s1_next;
            r_s2 <= w_s2_next;
            r_s3 <= w_s3_next;
        end
    end

    assign out_valid = r_s3.flags.valid;
    assign out_p     = r_s3.data;
    assign out_tag   = r_s3.tag;

    // The mode flag travels with the operation but is consumed in S1
    assign w_unused_flags = r_s1.flags.is_signed ^ r_s2.flags.is_signed ^
                            r_s3.flags.is_signed;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_multiplier
//  Description : Scoreboard bench for pipelined_multiplier (WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_multiplier;

    localparam int W = 4;
    localparam int T = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;
    logic [T-1:0]   in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic [T-1:0]   out_tag;

    pipelined_multiplier #(
        .WIDTH      (W),
        .TAG_W      (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] p;
        logic [T-1:0]   tag;
        int             acc;
        bit             lat;
    } exp_t;

    exp_t           exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic [2*W-1:0] exp_cur;
    bit             lat_cur;
    logic [T-1:0]   tag_ctr;
    bit             bp_en;
    logic           ready_force;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Independent reference: sign-extend as integers and multiply
    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        int a = int'(x);
        int b = int'(y);
        if (s && x[W-1]) a = a - (1 << W);
        if (s && y[W-1]) b = b - (1 << W);
        return (2*W)'(a * b);
    endfunction

    // Scoreboard: records accepted operations, checks presented products
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", {24'd0, out_p}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("product", {24'd0, out_p}, {24'd0, e.p});
                        check("tag", {28'd0, out_tag}, {28'd0, e.tag});
                        if (e.lat) check("latency", cyc - e.acc, 3);
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back('{p: exp_cur, tag: in_tag, acc: cyc, lat: lat_cur});
                end
            end
        end
    endtask

    // Consumer: either random backpressure or a forced level
    task automatic ready_driver();
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = bp_en ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    endtask

    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] e, input bit lat);
        int n = 0;
        in_valid  = 1'b1;
        in_signed = s;
        in_x      = x;
        in_y      = y;
        in_tag    = tag_ctr;
        exp_cur   = e;
        lat_cur   = lat;
        tag_ctr   = tag_ctr + 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [T-1:0] t1;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_x        = '0;
        in_y        = '0;
        in_tag      = '0;
        exp_cur     = '0;
        lat_cur     = 1'b0;
        tag_ctr     = '0;
        bp_en       = 1'b0;
        ready_force = 1'b1;

        fork
            monitor();
            ready_driver();
            begin
                #300000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_p", {24'd0, out_p}, 32'd0);
        check("rst_out_tag", {28'd0, out_tag}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed vectors, hand-computed, back-to-back with latency check
        issue(1'b0, 4'hF, 4'hF, 8'hE1, 1'b1);
        issue(1'b1, 4'h8, 4'h8, 8'h40, 1'b1);
        issue(1'b1, 4'h8, 4'h7, 8'hC8, 1'b1);
        issue(1'b1, 4'hF, 4'h1, 8'hFF, 1'b1);
        issue(1'b0, 4'hF, 4'h1, 8'h0F, 1'b1);
        issue(1'b1, 4'h7, 4'h7, 8'h31, 1'b1);
        issue(1'b1, 4'h9, 4'h3, 8'hEB, 1'b1);
        issue(1'b1, 4'hF, 4'hF, 8'h01, 1'b1);
        issue(1'b0, 4'hA, 4'h5, 8'h32, 1'b1);
        issue(1'b0, 4'h8, 4'h8, 8'h40, 1'b1);
        issue(1'b0, 4'h0, 4'h9, 8'h00, 1'b1);
        drain();

        // Stall: three operations in flight, consumer not ready for 5 cycles
        ready_force = 1'b0;
        @(posedge clk);
        #1;
        t1 = tag_ctr;
        issue(1'b1, 4'h9, 4'h3, 8'hEB, 1'b0);
        issue(1'b0, 4'hC, 4'h3, 8'h24, 1'b0);
        issue(1'b1, 4'hC, 4'h3, 8'hF4, 1'b0);
        in_valid  = 1'b1;
        in_signed = 1'b0;
        in_x      = 4'h6;
        in_y      = 4'h7;
        in_tag    = tag_ctr;
        exp_cur   = 8'h2A;
        lat_cur   = 1'b0;
        tag_ctr   = tag_ctr + 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_out_p", {24'd0, out_p}, 32'h0000_00EB);
            check("stall_out_tag", {28'd0, out_tag}, {28'd0, t1});
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset with all three stages holding work
        issue(1'b0, 4'h3, 4'h3, 8'h09, 1'b0);
        issue(1'b0, 4'h5, 4'h3, 8'h0F, 1'b0);
        issue(1'b1, 4'hE, 4'h2, 8'hFC, 1'b0);
        check("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b1, 4'h6, 4'hD, 8'hEE, 1'b1);
        drain();

        // Exhaustive, both modes, random backpressure
        bp_en = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    issue(s[0], x[W-1:0], y[W-1:0], ref_mul(s[0], x[W-1:0], y[W-1:0]), 1'b0);
        drain();
        bp_en       = 1'b0;
        ready_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back random stream, consumer always ready
        for (int i = 0; i < 100; i++) begin
            logic           s;
            logic [W-1:0]   x;
            logic [W-1:0]   y;
            s = 1'($urandom_range(0, 1));
            x = W'($urandom_range(0, 15));
            y = W'($urandom_range(0, 15));
            issue(s, x, y, ref_mul(s, x, y), 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_multiplier.md
# pipelined_multiplier

Parametrised, pipelined array multiplier that computes the full-width product of two WIDTH-bit operands in signed or unsigned mode. Operands enter through a valid/ready handshake, pass through a partial-product stage, a carry-save compression stage and a parallel-prefix final-add stage, and leave through a valid/ready handshake. It replaces fixed-width combinational multipliers wherever a registered, back-pressurable product stream is needed.

## Interface
- WIDTH, 8: operand width in bits (≥ 2); product is 2*WIDTH bits.
- TAG_W, 4: width of the opaque tag carried alongside each operation (≥ 1).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts operands this cycle.
- in_signed  in  1  1 = two's-complement operands/product, 0 = unsigned.
- in_x  in  WIDTH  multiplicand.
- in_y  in  WIDTH  multiplier.
- in_tag  in  TAG_W  tag, returned unchanged with the product.
- out_valid  out  1  product present.
- out_ready  in  1  consumer accepts the product this cycle.
- out_p  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of the operation producing out_p.

## Operation
- Three register stages, S1 (partial products), S2 (compressed sum/carry rows), S3 (final product). Each stage holds a valid bit, its data, its tag and its signed flag.
- S1: forms WIDTH partial-product rows x[i]&y[j]. In signed mode, Baugh-Wooley correction applies: the sign-row terms are inverted, and constant 1s are added at columns WIDTH and 2*WIDTH-1.
- S2: full-/half-adder reduction of all rows to two 2*WIDTH-bit rows (sum, carry).
- S3: sum + carry through a parallel-prefix adder (generate/propagate, black/grey cells). Result is truncated to 2*WIDTH bits and is exact for every operand pair in both modes.
- Handshake: a transfer occurs on a cycle where valid and ready are both 1. Producers hold valid/data stable until accepted.
- Flow control: stall = out_valid & ~out_ready. When stall = 1, all three stages hold their contents. When stall = 0, every stage advances: S1 loads the input (valid = in_valid & in_ready), S2 loads S1, S3 loads S2.
- in_ready = ~stall, combinational. Bubbles are not collapsed.
- out_valid, out_p and out_tag are driven directly from S3 registers.
- in_signed is sampled with the operands and travels with them. Mode may change every transaction.
- Reset, including mid-operation: every stage valid clears immediately. In-flight operations are discarded with no output. Data registers are don't-care, and tests mask them.

## Timing
- Latency: operands accepted on edge N appear on out_p at edge N+3 (visible in the cycle after edge N+3) when there is no stall.
- Throughput: one operation per cycle while out_ready = 1.
- Reset values: out_valid = 0, in_ready = 1, out_p = 0, out_tag = 0.
- Stall release: a stage advances on the same edge on which out_ready rises with out_valid = 1.
- Simultaneous accept and output: while S3 is valid and out_ready = 1, new input is accepted in the same cycle and no data is lost.
- Combinational paths: out_ready → in_ready only. No path exists from input data to output data.

## Structure
- Package mult_pkg holds:
  - LATENCY = 3;
  - a function giving the product width (2*WIDTH);
  - a typedef for the stage record {valid, signed, tag, data}, parametrised through the package or by module-level localparams.
- One sub-module, prefix_adder, with parameter N: N-bit two-operand parallel-prefix adder that outputs the sum only and has no carry-in. It is instantiated in S3 and is reusable elsewhere.
- Partial-product generation and compression are generate loops in the top module.

## Test plan
- WIDTH=4, unsigned, x=15, y=15 → out_p=0xE1 (225) exactly 3 cycles after acceptance; out_tag equals in_tag.
- WIDTH=4, signed, the following operand pairs:
  - x=0x8, y=0x8 (−8·−8) → out_p=0x40;
  - x=0x8, y=0x7 → 0xC8 (−56);
  - x=0xF, y=0x1 → 0xFF.
  Same x=0xF, y=0x1 unsigned → 0x0F.
- Back-to-back stream, 100 random pairs with mixed modes and out_ready=1 → one product per cycle, in order, tags matching, checked against a reference model.
- Hold out_ready=0 for 5 cycles with 3 operations in flight → in_ready=0 during the stall and out_p/out_tag stable. After release, all 3 results emerge in order with none lost or duplicated.
- Assert rst with S1–S3 valid → out_valid=0 immediately (asynchronous). After deassertion, the first new operation emerges with latency 3 and no stale output.
- Exhaustive WIDTH=4 (both modes, all 256 pairs) and WIDTH=8 random with random out_ready backpressure → every product matches the reference model.
